// File: rtl/cpu_pkg.sv
// Constants shared by the instruction sequencer and the return-address stack.
package cpu_pkg;

  localparam int unsigned PC_W = 9;
  localparam logic [PC_W-1:0] RST_VEC = 9'h1FF;

  localparam logic [3:0] OP_CALL  = 4'b1001;
  localparam logic [3:0] OP_RETLW = 4'b1000;

  localparam int unsigned STACK_DEPTH = 2;

endpackage

// File: rtl/call_stack_ptr.sv
// Write pointer and depth counter for the circular return-address stack,
// plus the full/empty decode.
module call_stack_ptr #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH)-1:0] sp_o,
  output logic [$clog2(DEPTH)-1:0] top_o,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned SP_W = $clog2(DEPTH);
  localparam int unsigned DW   = SP_W + 1;

  logic [SP_W-1:0] sp_q, sp_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            eff_push, eff_pop;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign sp_o    = sp_q;
  assign top_o   = sp_q - SP_W'(1);
  assign depth_o = depth_q;

  // Simultaneous push/pop on a non-empty stack replaces the top in place;
  // on an empty stack it degenerates into a plain push.
  assign eff_push = push_i & (~pop_i | empty_o);
  assign eff_pop  = pop_i & ~push_i;

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (eff_push) begin
      sp_d = sp_q + SP_W'(1);
      if (!full_o) depth_d = depth_q + DW'(1);
    end else if (eff_pop) begin
      sp_d = sp_q - SP_W'(1);
      if (!empty_o) depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/call_stack.sv
// PIC-style circular return-address stack: flop entry array, zero-latency
// top-of-stack read and sticky overflow/underflow flags for debug.
module call_stack
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH   = cpu_pkg::STACK_DEPTH,
  parameter int unsigned     AW      = cpu_pkg::PC_W,
  parameter logic [AW-1:0]   RST_VEC = cpu_pkg::RST_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          stack_psh,
  output logic [AW-1:0]          stack_pop,
  input  logic                   clr_flags,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic                   unf
);

  localparam int unsigned SP_W = $clog2(DEPTH);

  logic [AW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   mem_d [DEPTH];
  logic [SP_W-1:0] sp, top, wr_idx;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            ovf_set, unf_set;

  call_stack_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .sp_o    (sp),
    .top_o   (top),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );

  assign stack_pop = mem_q[top];
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  assign wr_idx  = (pop && !empty) ? top : sp;
  assign ovf_set = push & ~pop & full;
  assign unf_set = pop & ~push & empty;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_idx] = stack_psh;
  end

  // Flag set beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (unf_set) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= RST_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed, table-driven bench for call_stack with DEPTH=2.
module tb_call_stack;

  logic       clk = 1'b0;
  logic       rst, push, pop, clr_flags;
  logic [8:0] stack_psh, stack_pop;
  logic [1:0] depth;
  logic       full, empty, ovf, unf;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic       rst, push, pop, clr;
    logic [8:0] psh;
    logic [8:0] e_top;
    logic [1:0] e_depth;
    logic       e_full, e_empty, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  call_stack #(
    .DEPTH   (2),
    .AW      (9),
    .RST_VEC (9'h1FF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .stack_psh (stack_psh),
    .stack_pop (stack_pop),
    .clr_flags (clr_flags),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic pu, input logic po,
                     input logic c, input logic [8:0] d, input logic [8:0] t,
                     input logic [1:0] dp, input logic f, input logic e,
                     input logic ov, input logic un);
    vec_t v;
    v.name = name; v.rst = r; v.push = pu; v.pop = po; v.clr = c; v.psh = d;
    v.e_top = t; v.e_depth = dp; v.e_full = f; v.e_empty = e; v.e_ovf = ov; v.e_unf = un;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic pu, input logic po, input logic c,
                       input logic [8:0] d);
    rst = r; push = pu; pop = po; clr_flags = c; stack_psh = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);

    //   name         rst push pop clr psh     top     dp f e ov un
    add("reset",      1, 0, 0, 0, 9'h000, 9'h1FF, 0, 0, 1, 0, 0);
    add("idle1",      0, 0, 0, 0, 9'h000, 9'h1FF, 0, 0, 1, 0, 0);
    add("idle2",      0, 0, 0, 0, 9'h000, 9'h1FF, 0, 0, 1, 0, 0);
    add("idle3",      0, 0, 0, 0, 9'h000, 9'h1FF, 0, 0, 1, 0, 0);
    add("push012",    0, 1, 0, 0, 9'h012, 9'h012, 1, 0, 0, 0, 0);
    add("push034",    0, 1, 0, 0, 9'h034, 9'h034, 2, 1, 0, 0, 0);
    add("pop_a",      0, 0, 1, 0, 9'h000, 9'h012, 1, 0, 0, 0, 0);
    add("pop_b",      0, 0, 1, 0, 9'h000, 9'h034, 0, 0, 1, 0, 0);
    add("push001",    0, 1, 0, 0, 9'h001, 9'h001, 1, 0, 0, 0, 0);
    add("push002",    0, 1, 0, 0, 9'h002, 9'h002, 2, 1, 0, 0, 0);
    add("push003ovf", 0, 1, 0, 0, 9'h003, 9'h003, 2, 1, 0, 1, 0);
    add("pop_ovf1",   0, 0, 1, 0, 9'h000, 9'h002, 1, 0, 0, 1, 0);
    add("pop_ovf2",   0, 0, 1, 0, 9'h000, 9'h003, 0, 0, 1, 1, 0);
    add("clr_ovf",    0, 0, 0, 1, 9'h000, 9'h003, 0, 0, 1, 0, 0);
    add("pop_empty",  0, 0, 1, 0, 9'h000, 9'h002, 0, 0, 1, 0, 1);
    add("clr_unf",    0, 0, 0, 1, 9'h000, 9'h002, 0, 0, 1, 0, 0);
    add("pop_clr",    0, 0, 1, 1, 9'h000, 9'h003, 0, 0, 1, 0, 1);
    add("clr_unf2",   0, 0, 0, 1, 9'h000, 9'h003, 0, 0, 1, 0, 0);
    add("push050",    0, 1, 0, 0, 9'h050, 9'h050, 1, 0, 0, 0, 0);
    add("pushpop0AA", 0, 1, 1, 0, 9'h0AA, 9'h0AA, 1, 0, 0, 0, 0);
    add("pop_to0",    0, 0, 1, 0, 9'h000, 9'h003, 0, 0, 1, 0, 0);
    add("pop_unf",    0, 0, 1, 0, 9'h000, 9'h0AA, 0, 0, 1, 0, 1);
    add("clr_unf3",   0, 0, 0, 1, 9'h000, 9'h0AA, 0, 0, 1, 0, 0);
    add("pp_empty",   0, 1, 1, 0, 9'h0BB, 9'h0BB, 1, 0, 0, 0, 0);
    add("push0CC",    0, 1, 0, 0, 9'h0CC, 9'h0CC, 2, 1, 0, 0, 0);
    add("ovf_clr",    0, 1, 0, 1, 9'h0DD, 9'h0DD, 2, 1, 0, 1, 0);
    add("rst_push",   1, 1, 0, 0, 9'h0EE, 9'h1FF, 0, 0, 1, 0, 0);
    add("pop_rstval", 0, 0, 1, 0, 9'h000, 9'h1FF, 0, 0, 1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].psh);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".top"},   32'(stack_pop), 32'(vecs[i].e_top));
      chk({vecs[i].name, ".depth"}, 32'(depth),     32'(vecs[i].e_depth));
      chk({vecs[i].name, ".full"},  32'(full),      32'(vecs[i].e_full));
      chk({vecs[i].name, ".empty"}, 32'(empty),     32'(vecs[i].e_empty));
      chk({vecs[i].name, ".ovf"},   32'(ovf),       32'(vecs[i].e_ovf));
      chk({vecs[i].name, ".unf"},   32'(unf),       32'(vecs[i].e_unf));
    end

    // Push data must not show before the edge; pop must read top with zero latency.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 9'h000);
    @(posedge clk); #1;
    chk("seq.clr_unf", 32'(unf), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h111);
    #1;
    chk("seq.push_pre_edge", 32'(stack_pop), 32'h1FF);
    @(posedge clk); #1;
    chk("seq.push_post_edge", 32'(stack_pop), 32'h111);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    #1;
    chk("seq.pop_same_cycle", 32'(stack_pop), 32'h111);
    @(posedge clk); #1;
    chk("seq.pop_after", 32'(stack_pop), 32'h1FF);
    chk("seq.pop_depth", 32'(depth), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("seq.hold", 32'(stack_pop), 32'h1FF);
    chk("seq.hold_unf", 32'(unf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
